// File: rtl/order_tx_arbiter.sv
// order_tx_arbiter
//   Round-robin arbiter that accepts one fixed-size order packet at a time
//   from NUM_REQ requesters. It serializes the packet most significant byte
//   first onto an 8-bit AXI-Stream style output.
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst           asynchronous active-high reset
//   req_valid     per-requester packet pending
//   req_packet    packed packets, requester i at [PKT_W*i +: PKT_W]
//   req_ready     one-hot accept strobe, only in IDLE
//   m_axis_tdata  serialized byte
//   m_axis_tvalid byte valid (SEND state)
//   m_axis_tready downstream accept
//   m_axis_tlast  final byte of the packet
//   grant_id      requester being served, meaningful while busy
//   busy          high in SEND
//   pkt_count     completed packets, wraps at 16 bits
module order_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PKT_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*8*PKT_BYTES-1:0] req_packet,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [7:0]                   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [2:0]                   grant_id,
  output logic                         busy,
  output logic [15:0]                  pkt_count
);

  localparam int PKT_W = 8 * PKT_BYTES;
  localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_nxt;
  logic [2:0]         last_grant;
  logic [IDX_W-1:0]   idx;
  logic [PKT_W-1:0]   pkt_reg;

  logic [2:0]         cand;
  logic [2:0]         pick;
  logic               pick_vld;
  logic [IDX_W-1:0]   byte_sel;
  logic               accept;
  logic               byte_done;
  logic               pkt_done;

  // Rotating priority search: first pending requester after last_grant.
  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = 3'((32'(last_grant) + off) % NUM_REQ);
      if (!pick_vld && |(req_valid & (NUM_REQ'(1) << cand))) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    req_ready     = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    busy          = 1'b0;
    state_nxt     = state;
    byte_sel      = IDX_W'(PKT_BYTES - 1) - idx;

    // req_ready is held low during reset so every output reads 0 under rst.
    if (state == IDLE && !rst && pick_vld)
      req_ready = NUM_REQ'(1) << pick;

    if (state == SEND) begin
      busy          = 1'b1;
      m_axis_tvalid = 1'b1;
      m_axis_tdata  = 8'(pkt_reg >> {byte_sel, 3'b000});
      m_axis_tlast  = (idx == IDX_W'(PKT_BYTES - 1));
    end

    accept    = |(req_valid & req_ready);
    byte_done = m_axis_tvalid & m_axis_tready;
    pkt_done  = byte_done & m_axis_tlast;

    case (state)
      IDLE:    if (accept)   state_nxt = SEND;
      SEND:    if (pkt_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 3'(NUM_REQ - 1);
      idx        <= '0;
      pkt_reg    <= '0;
      grant_id   <= '0;
      pkt_count  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pkt_reg    <= PKT_W'(req_packet >> (PKT_W * pick));
        grant_id   <= pick;
        last_grant <= pick;
        idx        <= '0;
      end else if (byte_done) begin
        if (m_axis_tlast) begin
          idx       <= '0;
          pkt_count <= pkt_count + 16'd1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_order_tx_arbiter.sv
// Bench for order_tx_arbiter. A queue-based packet model is checked on every
// falling edge. Directed scenarios pin the model against literal byte streams,
// grant orders and counts.
module tb_order_tx_arbiter;

  localparam int N  = 4;
  localparam int PB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*32-1:0]   req_packet;
  logic [N-1:0]      req_ready;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [2:0]        grant_id;
  logic              busy;
  logic [15:0]       pkt_count;

  order_tx_arbiter #(.NUM_REQ(N), .PKT_BYTES(PB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_packet(req_packet),
    .req_ready(req_ready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .grant_id(grant_id), .busy(busy),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Logs of what was actually handshaked, filled by the compare process.
  logic [7:0]  sent[$];
  int unsigned glog[$];
  int          tlast_cnt = 0;

  // Model: pending bytes of the current packet, last granted requester, count.
  bit          m_busy = 1'b0;
  logic [7:0]  mq[$];
  int unsigned m_gid  = 0;
  int unsigned m_last = N - 1;
  logic [15:0] m_count = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] e_ready;
    logic [31:0]  slice;
    int unsigned  g;
    if (rst) begin
      chk("rst_ready",  32'(req_ready), 0);
      chk("rst_tvalid", 32'(m_axis_tvalid), 0);
      chk("rst_tdata",  32'(m_axis_tdata), 0);
      chk("rst_tlast",  32'(m_axis_tlast), 0);
      chk("rst_busy",   32'(busy), 0);
      chk("rst_gid",    32'(grant_id), 0);
      chk("rst_count",  32'(pkt_count), 0);
      m_busy  = 1'b0;
      mq.delete();
      m_last  = N - 1;
      m_gid   = 0;
      m_count = '0;
    end else begin
      e_ready = '0;
      g = 0;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          if (e_ready == 0 && req_valid[(m_last + k) % N]) begin
            e_ready[(m_last + k) % N] = 1'b1;
            g = (m_last + k) % N;
          end
        end
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("tvalid",    32'(m_axis_tvalid), 32'(m_busy));
      chk("tdata",     32'(m_axis_tdata), m_busy ? 32'(mq[0]) : 32'd0);
      chk("tlast",     32'(m_axis_tlast), 32'(m_busy && mq.size() == 1));
      chk("busy",      32'(busy), 32'(m_busy));
      chk("pkt_count", 32'(pkt_count), 32'(m_count));
      if (m_busy) chk("grant_id", 32'(grant_id), m_gid);

      if (m_busy && m_axis_tready) begin
        sent.push_back(mq[0]);
        if (mq.size() == 1) tlast_cnt++;
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_busy  = 1'b0;
          m_count = m_count + 16'd1;
        end
      end else if (!m_busy && e_ready != 0) begin
        slice = req_packet[32*g +: 32];
        for (int b = PB - 1; b >= 0; b--) mq.push_back(slice[8*b +: 8]);
        m_busy = 1'b1;
        m_gid  = g;
        m_last = g;
        glog.push_back(g);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    if (busy) chk(nm, 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    sent.delete();
    glog.delete();
    tlast_cnt = 0;
  endtask

  task automatic chk_sent(input string nm, input logic [63:0] exp, input int cnt);
    chk({nm, "_len"}, 32'(sent.size()), 32'(cnt));
    for (int i = 0; i < cnt && i < sent.size(); i++)
      chk(nm, 32'(sent[i]), 32'(exp[8*(cnt-1-i) +: 8]));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_packet = '0;
    m_axis_tready = 1'b1;
    step(2);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_count", 32'(pkt_count), 0);
    rst = 1'b0;

    // Single request, requester 0.
    do_reset();
    req_packet[31:0] = 32'h0102_0304;
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    wait_idle("single_timeout", 20);
    chk_sent("single_bytes", 64'h0102_0304, 4);
    chk("single_gid", glog.size() > 0 ? glog[0] : 32'hFFFF, 0);
    chk("single_count", 32'(pkt_count), 1);
    chk("single_tlast", 32'(tlast_cnt), 1);

    // Round robin with every requester held valid.
    do_reset();
    req_packet = {32'h4040_4040, 32'h3030_3030, 32'h2020_2020, 32'h1010_1010};
    req_valid = 4'b1111;
    begin
      int n = 0;
      while (glog.size() < 5 && n < 100) begin
        step(1);
        n++;
      end
      if (glog.size() < 5) chk("rr_timeout", 32'(glog.size()), 5);
    end
    req_valid = '0;
    wait_idle("rr_idle_timeout", 20);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      chk("rr_order", glog[i], (i == 4) ? 0 : i);
    chk("rr_count", 32'(pkt_count), 5);

    // Backpressure on the third byte.
    do_reset();
    req_packet[31:0] = 32'hAABB_CCDD;
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    step(2);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data", 32'(m_axis_tdata), 32'hCC);
      chk("bp_hold_valid", 32'(m_axis_tvalid), 1);
      step(1);
    end
    m_axis_tready = 1'b1;
    wait_idle("bp_timeout", 20);
    chk_sent("bp_bytes", 64'hAABB_CCDD, 4);

    // Packet slice changed after acceptance.
    do_reset();
    req_packet[95:64] = 32'h1122_3344;
    req_valid = 4'b0100;
    step(1);
    req_packet[95:64] = 32'hFFFF_FFFF;
    req_valid = '0;
    wait_idle("pac_timeout", 20);
    chk_sent("pac_bytes", 64'h1122_3344, 4);
    chk("pac_gid", glog.size() > 0 ? glog[0] : 32'hFFFF, 2);

    // Reset in the middle of a packet.
    do_reset();
    req_packet[31:0] = 32'h0102_0304;
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    step(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("mid_rst_tdata", 32'(m_axis_tdata), 0);
    step(2);
    rst = 1'b0;
    chk("mid_rst_count", 32'(pkt_count), 0);
    chk("mid_rst_tlast", 32'(tlast_cnt), 0);
    step(2);
    chk("mid_rst_idle", 32'(busy), 0);
    req_packet[31:0] = 32'hA1B2_C3D4;
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    wait_idle("mid_rst_timeout", 20);
    chk_sent("mid_rst_bytes", 64'h0102_A1B2_C3D4, 6);
    chk("mid_rst_count2", 32'(pkt_count), 1);

    // Counter wrap through 0xFFFF.
    force dut.pkt_count = 16'hFFFF;
    m_count = 16'hFFFF;
    step(1);
    release dut.pkt_count;
    step(1);
    chk("wrap_pre", 32'(pkt_count), 32'hFFFF);
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    wait_idle("wrap_timeout", 20);
    chk("wrap_post", 32'(pkt_count), 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      req_valid = N'($urandom);
      req_packet = {$urandom, $urandom, $urandom, $urandom};
      m_axis_tready = ($urandom % 10) < 7;
      rst = ($urandom % 100) == 0;
      step(1);
    end
    rst = 1'b0;
    req_valid = '0;
    m_axis_tready = 1'b1;
    step(1);
    wait_idle("rand_timeout", 20);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
